carry_lookahead_adder_4b: RTL and testbench
===========================================

Name: carry_lookahead_adder_4b

Overview:
- Registered carry-lookahead adder: computes iA + iB + iCarryIn and presents a sum and carry-out one clock later.
- Default configuration is a single 4-bit lookahead group.
- Wider configurations chain 4-bit groups through a second-level lookahead unit, not a ripple chain.
- Used as the basic adder primitive of the arithmetic accelerator datapath.

Parameters:
- WIDTH, 4, operand width in bits; must be a multiple of 4, range 4..16; otherwise elaboration fails.

Ports:
- iClk  input  1  rising-edge clock
- iRst  input  1  synchronous, active-high reset
- iA  input  WIDTH  operand A, unsigned
- iB  input  WIDTH  operand B, unsigned
- iCarryIn  input  1  carry-in, weight 1
- iValid  input  1  operands valid this cycle
- oSum  output  WIDTH  registered sum bits [WIDTH-1:0]
- oCarry  output  1  registered carry-out, bit WIDTH of the result
- oGroupP  output  1  registered group propagate: AND of all per-bit p
- oGroupG  output  1  registered group generate, independent of iCarryIn
- oValid  output  1  registered copy of iValid

Behaviour:
- One clock domain; all outputs come directly from flops.
- Reset: when iRst=1 at a rising edge, oSum=0, oCarry=0, oGroupP=0, oGroupG=0 and oValid=0 after that edge. Reset takes priority over all inputs. Reset mid-stream discards the operands sampled on that edge.
- Latency: 1 cycle. Operands sampled at edge N appear on outputs after edge N; full throughput, a new operation every cycle.
- The result registers load every non-reset cycle regardless of iValid; iValid only qualifies oValid. Consumers must ignore oSum/oCarry when oValid=0.
- Arithmetic: {oCarry, oSum} = iA + iB + iCarryIn, computed exactly in WIDTH+1 bits. No overflow flag; unsigned interpretation only.
- Per-bit terms: g[i]=iA[i]&iB[i]; p[i]=iA[i]^iB[i]; sum[i]=p[i]^c[i]; c[0]=iCarryIn.
- Within a 4-bit group, carries use flattened lookahead equations, e.g. c2 = g1 | p1&g0 | p1&p0&c0. No carry may depend on a preceding carry signal.
- Group terms: P = p3&p2&p1&p0; G = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0.
- Group carry-out = G | P&cin.
- For WIDTH>4, group carry-ins come from a second-level lookahead over group (P,G) pairs using the same flattened form.
- oGroupP and oGroupG report the whole-word P and G.
- Boundaries:
  - all-ones + all-zeros + carry-in 1 wraps oSum to 0 with oCarry=1.
  - X/Z on inputs is not handled; inputs are assumed driven when iValid=1.
- The combinational core is purely combinational; no latches.

Decomposition:
- Package cla_pkg holds the constant CLA_GROUP_W=4 and a function checking that WIDTH is a legal multiple.
- Sub-module cla_block_4b is the natural split: purely combinational 4-bit group.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: sum[3:0], grp_p, grp_g, cout.
- The top instantiates WIDTH/4 of these, adds the second-level lookahead and the output register stage.

Test Plan:
- Reset: assert iRst with iA=4'hF, iB=4'hF, iCarryIn=1, iValid=1 -> all outputs 0 after the edge. Deassert -> next cycle oSum=4'hF, oCarry=1, oValid=1.
- Full carry chain: iA=15, iB=0, iCarryIn=1 -> oSum=0, oCarry=1, oGroupP=1, oGroupG=0.
- Propagate without carry: iA=9, iB=6, iCarryIn=0 -> oSum=15, oCarry=0, oGroupP=1. The same with iCarryIn=1 -> oSum=0, oCarry=1.
- Generate: iA=8, iB=8, iCarryIn=0 -> oSum=0, oCarry=1, oGroupG=1. Also iA=7, iB=8, iCarryIn=1 -> 16, i.e. oSum=0, oCarry=1.
- Back-to-back plus valid gating: apply 3+4+0, 12+5+1 and 0+0+0 on consecutive cycles with iValid=1,0,1.
  - Outputs, each one cycle later: 7/0, 2/1 and 0/0.
  - oValid follows as 1,0,1.
- Randomised: 500 random {iA,iB,iCarryIn} vectors per WIDTH in {4,8,16}; {oCarry,oSum} must equal iA+iB+iCarryIn one cycle later. Exhaustive 512-case sweep for WIDTH=4.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry-lookahead adder slice.
// Carry helper builds flattened sum-of-products terms, never a carry chain.
package cla_pkg;

    localparam int CLA_GROUP_W = 4;

    function automatic bit cla_width_ok(input int w);
        return (w % CLA_GROUP_W == 0) && (w >= CLA_GROUP_W) && (w <= 4 * CLA_GROUP_W);
    endfunction

    // Carry into position n of a lookahead over n (p,g) pairs:
    // OR over j of g[j] & p[n-1:j+1], plus p[n-1:0] & cin.
    function automatic logic cla_carry(
        input logic [3:0] p,
        input logic [3:0] g,
        input logic       cin,
        input int         n
    );
        logic c;
        logic t;
        c = cin;
        for (int i = 0; i < n; i++) begin
            c = c & p[i];
        end
        for (int j = 0; j < n; j++) begin
            t = g[j];
            for (int i = j + 1; i < n; i++) begin
                t = t & p[i];
            end
            c = c | t;
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_block_4b.sv
// Purely combinational 4-bit lookahead group: sum, group P/G and carry-out.
// No state, no flow control; every carry is a flattened function of p, g and cin.
module cla_block_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       grp_p,
    output logic       grp_g,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        c[0]  = cin;
        c[1]  = g[0] | (p[0] & cin);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        grp_p = &p;
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        cout  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
        sum   = p ^ c;
    end

endmodule

// File: rtl/carry_lookahead_adder_4b.sv
// Registered carry-lookahead adder, 1-cycle latency, new operands every cycle.
// No backpressure: result flops load every non-reset cycle, iValid only qualifies oValid.
module carry_lookahead_adder_4b
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iCarryIn,
    input  logic             iValid,
    output logic [WIDTH-1:0] oSum,
    output logic             oCarry,
    output logic             oGroupP,
    output logic             oGroupG,
    output logic             oValid
);

    localparam int NG = WIDTH / CLA_GROUP_W;

    generate
        if (!cla_width_ok(WIDTH)) begin : g_bad_width
            $fatal(1, "carry_lookahead_adder_4b: WIDTH must be a multiple of 4 in 4..16");
        end
    endgenerate

    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    blk_cout_unused;
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] sum_w;
    logic             word_p;
    logic             word_g;

    genvar k;
    generate
        for (k = 0; k < NG; k++) begin : g_blk
            cla_block_4b u_blk (
                .a     (iA[k*CLA_GROUP_W +: CLA_GROUP_W]),
                .b     (iB[k*CLA_GROUP_W +: CLA_GROUP_W]),
                .cin   (grp_c[k]),
                .sum   (sum_w[k*CLA_GROUP_W +: CLA_GROUP_W]),
                .grp_p (grp_p[k]),
                .grp_g (grp_g[k]),
                .cout  (blk_cout_unused[k])
            );
        end
    endgenerate

    // Second-level lookahead: group carries come straight from group (P,G) pairs.
    logic [3:0] pad_p;
    logic [3:0] pad_g;

    always_comb begin
        pad_p = '0;
        pad_g = '0;
        for (int i = 0; i < NG; i++) begin
            pad_p[i] = grp_p[i];
            pad_g[i] = grp_g[i];
        end
        grp_c    = '0;
        grp_c[0] = iCarryIn;
        for (int i = 1; i <= NG; i++) begin
            grp_c[i] = cla_carry(pad_p, pad_g, iCarryIn, i);
        end
        word_p = &grp_p;
        word_g = cla_carry(pad_p, pad_g, 1'b0, NG);
    end

    logic [WIDTH-1:0] sum_d,   sum_q;
    logic             carry_d, carry_q;
    logic             gp_d,    gp_q;
    logic             gg_d,    gg_q;
    logic             valid_d, valid_q;

    always_comb begin
        sum_d   = sum_w;
        carry_d = grp_c[NG];
        gp_d    = word_p;
        gg_d    = word_g;
        valid_d = iValid;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            gp_q    <= 1'b0;
            gg_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            gp_q    <= gp_d;
            gg_q    <= gg_d;
            valid_q <= valid_d;
        end
    end

    assign oSum    = sum_q;
    assign oCarry  = carry_q;
    assign oGroupP = gp_q;
    assign oGroupG = gg_q;
    assign oValid  = valid_q;

endmodule

// File: tb/tb_carry_lookahead_adder_4b.sv
// Bench for carry_lookahead_adder_4b at WIDTH 4, 8 and 16 against an arithmetic model.
module tb_carry_lookahead_adder_4b;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  a4, b4, s4;
    logic [7:0]  a8, b8, s8;
    logic [15:0] a16, b16, s16;
    logic        ci4, v4, c4, p4, g4, ov4;
    logic        ci8, v8, c8, p8, g8, ov8;
    logic        ci16, v16, c16, p16, g16, ov16;

    int n_cmp = 0;
    int n_err = 0;

    carry_lookahead_adder_4b #(.WIDTH(4)) dut4 (
        .iClk(clk), .iRst(rst), .iA(a4), .iB(b4), .iCarryIn(ci4), .iValid(v4),
        .oSum(s4), .oCarry(c4), .oGroupP(p4), .oGroupG(g4), .oValid(ov4)
    );
    carry_lookahead_adder_4b #(.WIDTH(8)) dut8 (
        .iClk(clk), .iRst(rst), .iA(a8), .iB(b8), .iCarryIn(ci8), .iValid(v8),
        .oSum(s8), .oCarry(c8), .oGroupP(p8), .oGroupG(g8), .oValid(ov8)
    );
    carry_lookahead_adder_4b #(.WIDTH(16)) dut16 (
        .iClk(clk), .iRst(rst), .iA(a16), .iB(b16), .iCarryIn(ci16), .iValid(v16),
        .oSum(s16), .oCarry(c16), .oGroupP(p16), .oGroupG(g16), .oValid(ov16)
    );

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       vld;
        logic [3:0] sum;
        logic       carry;
        logic       p;
        logic       g;
        logic       ov;
    } vec_t;

    vec_t tbl[8];

    // Packed result {valid, G, P, carry, sum[15:0]}. P: every bit pair differs;
    // G: the operands alone carry out of the word.
    function automatic logic [19:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic v);
        logic [16:0] full;
        logic [16:0] nocin;
        logic [15:0] mask;
        logic        p;
        mask  = 16'((32'd1 << w) - 32'd1);
        full  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        nocin = {1'b0, a} + {1'b0, b};
        p     = (((a ^ b) & mask) == mask);
        return {v, nocin[w], p, full[w], full[15:0] & mask};
    endfunction

    function automatic logic [19:0] act4();
        return {ov4, g4, p4, c4, 12'd0, s4};
    endfunction
    function automatic logic [19:0] act8();
        return {ov8, g8, p8, c8, 8'd0, s8};
    endfunction
    function automatic logic [19:0] act16();
        return {ov16, g16, p16, c16, s16};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got valid/G/P/carry/sum=%b/%b/%b/%b/%h expected %b/%b/%b/%b/%h",
                     name, act[19], act[18], act[17], act[16], act[15:0],
                     exp[19], exp[18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    initial begin
        tbl[0] = '{"full_chain",   4'd15, 4'd0, 1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{"prop_no_cin",  4'd9,  4'd6, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{"prop_cin",     4'd9,  4'd6, 1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{"generate",     4'd8,  4'd8, 1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{"gen_via_cin",  4'd7,  4'd8, 1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{"b2b_3p4",      4'd3,  4'd4, 1'b0, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{"b2b_12p5c",    4'd12, 4'd5, 1'b1, 1'b0, 4'd2,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{"b2b_zero",     4'd0,  4'd0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1};

        // Reset edge with live all-ones operands must still clear everything.
        rst = 1'b1;
        a4 = 4'hF;     b4 = 4'hF;     ci4 = 1'b1;  v4 = 1'b1;
        a8 = 8'hFF;    b8 = 8'hFF;    ci8 = 1'b1;  v8 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1; v16 = 1'b1;
        @(posedge clk); #1;
        check("reset_w4",  act4(),  20'd0);
        check("reset_w8",  act8(),  20'd0);
        check("reset_w16", act16(), 20'd0);

        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_w4",  act4(),  {1'b1, 1'b1, 1'b0, 1'b1, 16'h000F});
        check("post_reset_w8",  act8(),  model(8,  16'h00FF, 16'h00FF, 1'b1, 1'b1));
        check("post_reset_w16", act16(), model(16, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1));

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a4 = tbl[i].a; b4 = tbl[i].b; ci4 = tbl[i].cin; v4 = tbl[i].vld;
            @(posedge clk); #1;
            check(tbl[i].name, act4(), {tbl[i].ov, tbl[i].g, tbl[i].p, tbl[i].carry, 12'd0, tbl[i].sum});
        end

        // Reset mid-stream drops the operands on that edge; stream resumes next cycle.
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd6; ci4 = 1'b0; v4 = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        check("midstream_reset", act4(), 20'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("after_midstream", act4(), {1'b1, 1'b0, 1'b0, 1'b0, 16'h000B});

        // Exhaustive WIDTH=4 sweep, wider instances fed random operands alongside.
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            a4 = 4'(i); b4 = 4'(i >> 4); ci4 = 1'(i >> 8); v4 = 1'($urandom_range(1, 0));
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); v8 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom); v16 = 1'($urandom);
            @(posedge clk); #1;
            check("sweep_w4",  act4(),  model(4,  {12'd0, a4}, {12'd0, b4}, ci4, v4));
            check("rand_w8",   act8(),  model(8,  {8'd0, a8}, {8'd0, b8}, ci8, v8));
            check("rand_w16",  act16(), model(16, a16, b16, ci16, v16));
        end

        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom); v4 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); v8 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom); v16 = 1'($urandom);
            if (i % 50 == 0) begin
                a16 = 16'hFFFF; b16 = 16'h0000; ci16 = 1'b1;
            end
            @(posedge clk); #1;
            check("rand_w4",  act4(),  model(4,  {12'd0, a4}, {12'd0, b4}, ci4, v4));
            check("rand_w8",  act8(),  model(8,  {8'd0, a8}, {8'd0, b8}, ci8, v8));
            check("rand_w16", act16(), model(16, a16, b16, ci16, v16));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
